div_host_master: RTL and testbench

DIV_HOST_MASTER -- requirements
Module: div_host_master

---
 rtl/div_host_pkg.sv | 38 +++
 rtl/div_host_rx_assembler.sv | 25 ++
 rtl/div_host_master.sv | 208 ++++++++++++++++++++
 tb/tb_div_host_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_host_pkg.sv
// Shared state encoding, sizing constants and operand byte selection for div_host_master.
package div_host_pkg;

    localparam int unsigned BYTES_PER_XFER         = 4;
    localparam int unsigned IDX_W                  = 2;
    localparam int unsigned BYTE_W                 = 8;
    localparam int unsigned WORD_W                 = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SEND,
        WAIT_ACK,
        GAP,
        RECV,
        ACK,
        FINISH
    } state_e;

    // Result payload as it arrives on Bus_in: byte 0 is the quotient LSB.
    typedef struct packed {
        logic [WORD_W-1:0] rem;
        logic [WORD_W-1:0] quo;
    } result_t;

    // Wire order of the operand bytes: D low, D high, M low, M high.
    function automatic logic [BYTE_W-1:0] operand_byte(
        input logic [WORD_W-1:0] d,
        input logic [WORD_W-1:0] m,
        input logic [IDX_W-1:0]  idx
    );
        logic [2*WORD_W-1:0] ops;
        ops = {m, d};
        return ops[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/div_host_rx_assembler.sv
// Byte-indexed capture of the four result bytes into the quotient/remainder register.
module div_host_rx_assembler
    import div_host_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [BYTE_W-1:0] byte_i,
    output result_t           data_o
);

    logic [2*WORD_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else if (cap_en_i) begin
            data_q[{idx_i, 3'b000} +: BYTE_W] <= byte_i;
        end
    end

    assign data_o = result_t'(data_q);

endmodule

// File: rtl/div_host_master.sv
// Host-side byte-serial master for a divider wrapper: sends D/M, collects Q/R.
// Optional wait timeout compiled in with DIV_HOST_TIMEOUT_EN.
module div_host_master
    import div_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] dividend,
    input  logic [WORD_W-1:0] divisor,
    input  logic              ready_for_input,
    input  logic              data_accepted,
    input  logic              buffer_ready,
    input  logic [BYTE_W-1:0] Bus_in,
    output logic [BYTE_W-1:0] Bus_out,
    output logic              data_ready,
    output logic              got_data,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] quotient,
    output logic [WORD_W-1:0] remainder
`ifdef DIV_HOST_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] dividend_q, dividend_d;
    logic [WORD_W-1:0] divisor_q, divisor_d;
    logic [BYTE_W-1:0] bus_out_q, bus_out_d;
    logic              data_ready_q, data_ready_d;
    logic              got_data_q, got_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] quotient_q, quotient_d;
    logic [WORD_W-1:0] remainder_q, remainder_d;
    logic              cap_en_c;
    result_t           rx_data;

`ifdef DIV_HOST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    div_host_rx_assembler u_rx (
        .clk      (clk),
        .rst      (rst),
        .cap_en_i (cap_en_c),
        .idx_i    (idx_q),
        .byte_i   (Bus_in),
        .data_o   (rx_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            bus_out_q    <= '0;
            data_ready_q <= 1'b0;
            got_data_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
`ifdef DIV_HOST_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            bus_out_q    <= bus_out_d;
            data_ready_q <= data_ready_d;
            got_data_q   <= got_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
`ifdef DIV_HOST_TIMEOUT_EN
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        bus_out_d    = bus_out_q;
        data_ready_d = data_ready_q;
        got_data_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        cap_en_c     = 1'b0;
`ifdef DIV_HOST_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    busy_d     = 1'b1;
                    state_d    = WAIT_RDY;
`ifdef DIV_HOST_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end
            end
            WAIT_RDY: begin
                if (ready_for_input) begin
                    idx_d        = '0;
                    bus_out_d    = operand_byte(dividend_q, divisor_q, '0);
                    data_ready_d = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (data_accepted) begin
                    data_ready_d = 1'b0;
                    state_d      = GAP;
                end else begin
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (data_accepted) begin
                    data_ready_d = 1'b0;
                    state_d      = GAP;
                end
            end
            GAP: begin
                // Index wraps to 0 after the last operand byte, ready for the receive phase.
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(BYTES_PER_XFER - 1)) begin
                    state_d      = RECV;
                end else begin
                    bus_out_d    = operand_byte(dividend_q, divisor_q, idx_q + IDX_W'(1));
                    data_ready_d = 1'b1;
                    state_d      = SEND;
                end
            end
            RECV: begin
                if (buffer_ready) begin
                    cap_en_c   = 1'b1;
                    got_data_d = 1'b1;
                    state_d    = ACK;
                end
            end
            ACK: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == IDX_W'(BYTES_PER_XFER - 1)) ? FINISH : RECV;
            end
            FINISH: begin
                quotient_d  = rx_data.quo;
                remainder_d = rx_data.rem;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef DIV_HOST_TIMEOUT_EN
        // Bound every handshake wait; an expired wait abandons the transaction without done.
        if ((state_q == WAIT_RDY || state_q == WAIT_ACK || state_q == RECV) && state_d == state_q) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_d    = 1'b1;
                data_ready_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (state_d != state_q && (state_d == WAIT_RDY || state_d == WAIT_ACK || state_d == RECV)) begin
            cnt_d = '0;
        end
`endif
    end

    assign Bus_out    = bus_out_q;
    assign data_ready = data_ready_q;
    assign got_data   = got_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign quotient   = quotient_q;
    assign remainder  = remainder_q;
`ifdef DIV_HOST_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_div_host_master.sv
// Self-checking bench for div_host_master: the bench plays the divider wrapper and
// predicts bytes and results from plain arithmetic on the operands.
module tb_div_host_master;

    localparam int unsigned TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        ready_for_input;
    logic        data_accepted;
    logic        buffer_ready;
    logic [7:0]  Bus_in;
    logic [7:0]  Bus_out;
    logic        data_ready;
    logic        got_data;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
`ifdef DIV_HOST_TIMEOUT_EN
    logic        timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_host_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .dividend        (dividend),
        .divisor         (divisor),
        .ready_for_input (ready_for_input),
        .data_accepted   (data_accepted),
        .buffer_ready    (buffer_ready),
        .Bus_in          (Bus_in),
        .Bus_out         (Bus_out),
        .data_ready      (data_ready),
        .got_data        (got_data),
        .busy            (busy),
        .done            (done),
        .quotient        (quotient),
        .remainder       (remainder)
`ifdef DIV_HOST_TIMEOUT_EN
        ,
        .timeout         (timeout)
`endif
    );

    // One transaction as seen by the divider wrapper. q_rsp/r_rsp are what the wrapper answers.
    task automatic do_xfer(input logic [15:0] d, input logic [15:0] m,
                           input logic [15:0] q_rsp, input logic [15:0] r_rsp,
                           input int acc_dly, input bit poke_start, input int abort_after);
        logic [7:0] exp_tx [4];
        logic [7:0] rsp [4];
        int guard;
        exp_tx[0] = 8'(d % 256);
        exp_tx[1] = 8'(d / 256);
        exp_tx[2] = 8'(m % 256);
        exp_tx[3] = 8'(m / 256);
        rsp[0] = 8'(q_rsp % 256);
        rsp[1] = 8'(q_rsp / 256);
        rsp[2] = 8'(r_rsp % 256);
        rsp[3] = 8'(r_rsp / 256);

        @(negedge clk);
        dividend = d; divisor = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end

        if (poke_start) begin
            dividend = 16'd5; divisor = 16'd2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ready_for_input = 1'b1;

        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (data_ready !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
            ready_for_input = 1'b0;
            n_tests++;
            if (data_ready !== 1'b1 || Bus_out !== exp_tx[i]) begin
                n_fail++;
                $display("FAIL tx_byte%0d: got ready=%b byte=%02h want ready=1 byte=%02h", i, data_ready, Bus_out, exp_tx[i]);
            end
            for (int k = 0; k < acc_dly; k++) begin
                // Noise on the result side must be ignored while sending.
                buffer_ready = 1'b1; Bus_in = 8'($urandom);
                @(negedge clk);
                n_tests++;
                if (data_ready !== 1'b1 || Bus_out !== exp_tx[i]) begin
                    n_fail++;
                    $display("FAIL tx_hold%0d: got ready=%b byte=%02h want ready=1 byte=%02h", i, data_ready, Bus_out, exp_tx[i]);
                end
            end
            buffer_ready = 1'b0; data_accepted = 1'b1;
            @(negedge clk);
            data_accepted = 1'b0;
            n_tests++;
            if (data_ready !== 1'b0) begin n_fail++; $display("FAIL tx_gap%0d: got ready=%b want 0", i, data_ready); end
        end

        for (int i = 0; i < 4; i++) begin
            if (i == abort_after) begin
                rst = 1'b0;
                @(negedge clk);
                n_tests++;
                if ({Bus_out, data_ready, got_data, busy, done, quotient, remainder} !== 45'd0) begin
                    n_fail++;
                    $display("FAIL reset_mid: got bus=%02h rdy=%b got=%b busy=%b done=%b q=%04h r=%04h want all 0",
                             Bus_out, data_ready, got_data, busy, done, quotient, remainder);
                end
                rst = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    n_tests++;
                    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd0) begin
                        n_fail++;
                        $display("FAIL reset_quiet: got done=%b busy=%b q=%04h want 0,0,0000", done, busy, quotient);
                    end
                end
                return;
            end
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                n_tests++;
                if (got_data !== 1'b0 || data_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rx_idle%0d: got got_data=%b ready=%b want 0,0", i, got_data, data_ready);
                end
            end
            buffer_ready = 1'b1; Bus_in = rsp[i];
            guard = 0;
            do begin @(negedge clk); guard++; end while (got_data !== 1'b1 && guard < 40);
            n_tests++;
            if (got_data !== 1'b1) begin n_fail++; $display("FAIL rx_ack%0d: got %b want 1 (timed out)", i, got_data); end
            buffer_ready = 1'b0; Bus_in = 8'($urandom);
            if (i < 3) begin
                @(negedge clk);
                n_tests++;
                if (got_data !== 1'b0) begin n_fail++; $display("FAIL rx_ack_width%0d: got %b want 0", i, got_data); end
            end
        end

        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b want 0", done); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== q_rsp || remainder !== r_rsp) begin
            n_fail++;
            $display("FAIL result: got done=%b busy=%b q=%04h r=%04h want 1,0,%04h,%04h", done, busy, quotient, remainder, q_rsp, r_rsp);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b ready=%b want 0,0", done, data_ready);
        end
    endtask

    // Wrapper that answers with the arithmetic result, or arbitrary bytes for M=0.
    task automatic run_model(input logic [15:0] d, input logic [15:0] m, input int dly,
                             input bit poke, input int abort_after);
        logic [15:0] q;
        logic [15:0] r;
        if (m != 16'd0) begin q = d / m; r = d % m; end
        else begin q = 16'($urandom); r = 16'($urandom); end
        do_xfer(d, m, q, r, dly, poke, abort_after);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({Bus_out, data_ready, got_data, busy, done, quotient, remainder} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset: got bus=%02h rdy=%b got=%b busy=%b done=%b q=%04h r=%04h want all 0",
                     Bus_out, data_ready, got_data, busy, done, quotient, remainder);
        end
`ifdef DIV_HOST_TIMEOUT_EN
        n_tests++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_model(16'd1000, 16'd7, 0, 1'b0, 4);
    endtask

    task automatic test_ack_delay;
        run_model(16'($urandom), 16'($urandom_range(1, 65535)), 5, 1'b0, 4);
    endtask

    task automatic test_start_while_busy;
        run_model(16'd50000, 16'd13, 1, 1'b1, 4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || data_ready !== 1'b0 || quotient !== 16'(50000 / 13) || remainder !== 16'(50000 % 13)) begin
                n_fail++;
                $display("FAIL start_ignored: got busy=%b rdy=%b q=%04h r=%04h want 0,0,%04h,%04h",
                         busy, data_ready, quotient, remainder, 16'(50000 / 13), 16'(50000 % 13));
            end
        end
    endtask

    task automatic test_zero_divisor;
        run_model(16'hFFFF, 16'h0000, 2, 1'b0, 4);
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            run_model(16'($urandom), 16'($urandom_range(0, 300)), int'($urandom_range(0, 4)), 1'b0, 4);
        end
    endtask

    task automatic test_reset_mid;
        run_model(16'd4321, 16'd10, 0, 1'b0, 4);
        run_model(16'd999, 16'd4, 0, 1'b0, 2);
    endtask

`ifdef DIV_HOST_TIMEOUT_EN
    task automatic test_timeout;
        ready_for_input = 1'b0;
        @(negedge clk);
        dividend = 16'd77; divisor = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= int'(TB_TIMEOUT) + 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (timeout !== (k >= int'(TB_TIMEOUT)) || done !== 1'b0 || busy !== (k < int'(TB_TIMEOUT))) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got to=%b done=%b busy=%b want to=%b done=0 busy=%b",
                         k, timeout, done, busy, k >= int'(TB_TIMEOUT), k < int'(TB_TIMEOUT));
            end
        end
        run_model(16'd300, 16'd9, 0, 1'b0, 4);
        n_tests++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", timeout); end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        ready_for_input = 1'b0; data_accepted = 1'b0; buffer_ready = 1'b0; Bus_in = '0;
        test_reset();
        test_basic();
        test_ack_delay();
        test_start_while_busy();
        test_zero_divisor();
        test_random();
        test_reset_mid();
`ifdef DIV_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
